// File: rtl/sram_responder.sv
// sram_responder: single-port SRAM target, byte-lane writes, 1-cycle read-first reads.
// Define SRAM_RESP_CONFREG_EN to add the 0xbfaf config window (TIMER/LED/SCRATCH).
module sram_responder #(
  parameter int    ADDR_WIDTH = 16,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic [15:0] led
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rdata_q;
  logic [31:0]           rdata_d;
  logic [31:0]           lane_mask;
  logic [31:0]           conf_rdata;
  logic                  win_sel;
  logic                  arr_req;

  assign idx       = sram_addr[ADDR_WIDTH+1:2];
  assign lane_mask = {{8{sram_wen[3]}}, {8{sram_wen[2]}},
                      {8{sram_wen[1]}}, {8{sram_wen[0]}}};

`ifdef SRAM_RESP_CONFREG_EN
  localparam logic [15:0] OFF_TIMER   = 16'he000;
  localparam logic [15:0] OFF_LED     = 16'hf000;
  localparam logic [15:0] OFF_SCRATCH = 16'hf020;

  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic [31:0] scratch_q;
  logic [31:0] scratch_d;
  logic [15:0] led_q;
  logic [15:0] led_d;
  logic        conf_wr;

  assign win_sel = (sram_addr[31:16] == 16'hbfaf);
  assign conf_wr = sram_en && win_sel && (sram_wen != 4'b0000);

  always_comb begin
    timer_d    = timer_q + 32'd1;
    led_d      = led_q;
    scratch_d  = scratch_q;
    conf_rdata = 32'h0;
    case (sram_addr[15:0])
      OFF_TIMER: begin
        conf_rdata = timer_q;
        if (conf_wr) begin
          timer_d = (timer_q & ~lane_mask)
                  | (sram_wdata & lane_mask);
        end
      end
      OFF_LED: begin
        conf_rdata = {16'h0, led_q};
        if (conf_wr) begin
          led_d = (led_q & ~lane_mask[15:0])
                | (sram_wdata[15:0] & lane_mask[15:0]);
        end
      end
      OFF_SCRATCH: begin
        conf_rdata = scratch_q;
        if (conf_wr) begin
          scratch_d = (scratch_q & ~lane_mask)
                    | (sram_wdata & lane_mask);
        end
      end
      default: conf_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q   <= 32'h0;
      led_q     <= 16'hffff;
      scratch_q <= 32'h0;
    end else begin
      timer_q   <= timer_d;
      led_q     <= led_d;
      scratch_q <= scratch_d;
    end
  end

  assign led = led_q;
`else
  logic unused_addr;

  assign win_sel     = 1'b0;
  assign conf_rdata  = 32'h0;
  assign led         = 16'hffff;
  assign unused_addr = &{1'b0, sram_addr[31:ADDR_WIDTH+2],
                         sram_addr[1:0]};
`endif

  assign arr_req = sram_en && !win_sel;

  always_comb begin
    rdata_d = rdata_q;
    if (sram_en) begin
      rdata_d = win_sel ? conf_rdata : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && arr_req) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_wen[i]) begin
          mem_q[idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign sram_rdata = rdata_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: randomized and directed checks against a word-map model.
// Config window checks build when SRAM_RESP_CONFREG_EN is defined.
module tb_sram_responder;
    localparam int AW    = 16;
    localparam int DEPTH = 2 ** AW;

    logic        clk;
    logic        reset;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;

    int checks;
    int errors;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_rd;

    sram_responder #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One request cycle; result is rdata one edge later.
    task automatic do_req(input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got);
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        #1;
        got = sram_rdata;
    endtask

    // Memory as a map of words; addresses wrap modulo the depth.
    task automatic model_req(input logic en, input logic [3:0] wen,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] exp);
        int unsigned k;
        logic [31:0] w;
        k = (addr / 4) % DEPTH;
        if (en) begin
            w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
            last_rd = w;
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
            end
            if (wen != 4'b0000) ref_mem[k] = w;
        end
        exp = last_rd;
    endtask

    task automatic test_reset;
        logic [31:0] got;
        logic [31:0] exp;
        reset = 1'b1;
        sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        last_rd = 32'h0;
        checks++;
        if (sram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want %h", sram_rdata, 32'h0);
        end
        checks++;
        if (led !== 16'hffff) begin
            errors++;
            $display("FAIL reset_led: got %h want %h", led, 16'hffff);
        end
        model_req(1'b1, 4'hf, 32'h0, 32'h1234_5678, exp);
        do_req(1'b1, 4'hf, 32'h0, 32'h1234_5678, got);
        model_req(1'b1, 4'h0, 32'h0, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h0, 32'h0, got);
        checks++;
        if (got !== 32'h1234_5678 || got !== exp) begin
            errors++;
            $display("FAIL first_read: got %h want %h", got, 32'h1234_5678);
        end
    endtask

    task automatic test_partial;
        logic [31:0] got;
        logic [31:0] exp;
        model_req(1'b1, 4'hf, 32'h100, 32'hAABB_CCDD, exp);
        do_req(1'b1, 4'hf, 32'h100, 32'hAABB_CCDD, got);
        model_req(1'b1, 4'b0010, 32'h100, 32'h0000_EE00, exp);
        do_req(1'b1, 4'b0010, 32'h100, 32'h0000_EE00, got);
        model_req(1'b1, 4'h0, 32'h100, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h100, 32'h0, got);
        checks++;
        if (got !== 32'hAABB_EEDD || got !== exp) begin
            errors++;
            $display("FAIL partial_write: got %h want %h", got, 32'hAABB_EEDD);
        end
        // en low with wen set must not write
        model_req(1'b0, 4'hf, 32'h100, 32'h1111_1111, exp);
        do_req(1'b0, 4'hf, 32'h100, 32'h1111_1111, got);
        model_req(1'b1, 4'h0, 32'h100, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h100, 32'h0, got);
        checks++;
        if (got !== 32'hAABB_EEDD) begin
            errors++;
            $display("FAIL en_qualifies_wen: got %h want %h", got, 32'hAABB_EEDD);
        end
    endtask

    task automatic test_read_first;
        logic [31:0] got;
        logic [31:0] exp;
        model_req(1'b1, 4'hf, 32'h40, 32'h1, exp);
        do_req(1'b1, 4'hf, 32'h40, 32'h1, got);
        model_req(1'b1, 4'hf, 32'h40, 32'h2, exp);
        do_req(1'b1, 4'hf, 32'h40, 32'h2, got);
        checks++;
        if (got !== 32'h1 || got !== exp) begin
            errors++;
            $display("FAIL read_first: got %h want %h", got, 32'h1);
        end
        model_req(1'b1, 4'h0, 32'h40, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h40, 32'h0, got);
        checks++;
        if (got !== 32'h2) begin
            errors++;
            $display("FAIL back_to_back: got %h want %h", got, 32'h2);
        end
    endtask

    task automatic test_idle_hold;
        logic [31:0] got;
        logic [31:0] exp;
        model_req(1'b1, 4'h0, 32'h40, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h40, 32'h0, got);
        for (int c = 0; c < 5; c++) begin
            model_req(1'b0, 4'h0, 32'h100, 32'h0, exp);
            do_req(1'b0, 4'h0, 32'h100, 32'h0, got);
            checks++;
            if (got !== 32'h2) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got %h want %h", c, got, 32'h2);
            end
        end
        model_req(1'b1, 4'h0, 32'h0004_0040, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h0004_0040, 32'h0, got);
        checks++;
        if (got !== 32'h2 || got !== exp) begin
            errors++;
            $display("FAIL alias: got %h want %h", got, 32'h2);
        end
    endtask

    task automatic test_random;
        logic [31:0] got;
        logic [31:0] exp;
        logic [31:0] pool [8];
        logic [31:0] a;
        logic [3:0]  wen;
        logic        en;
        logic [31:0] wd;
        for (int p = 0; p < 8; p++) begin
            pool[p] = $urandom_range(0, DEPTH - 1) * 4;
            wd = $urandom;
            model_req(1'b1, 4'hf, pool[p], wd, exp);
            do_req(1'b1, 4'hf, pool[p], wd, got);
        end
        for (int n = 0; n < 300; n++) begin
            a = pool[$urandom_range(0, 7)];
            // random alias bits that never hit the 0xbfaf window
            a = a | ($urandom_range(0, 255) << 20) | $urandom_range(0, 3);
            en  = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            wd  = $urandom;
            model_req(en, wen, a, wd, exp);
            do_req(en, wen, a, wd, got);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d] addr %h: got %h want %h", n, a, got, exp);
            end
        end
    endtask

`ifdef SRAM_RESP_CONFREG_EN
    task automatic test_confreg;
        logic [31:0] got;
        logic [31:0] exp;
        do_req(1'b1, 4'hf, 32'hbfaf_e000, 32'h100, got);
        do_req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, got);
        checks++;
        if (got !== 32'h100) begin
            errors++;
            $display("FAIL timer_load: got %h want %h", got, 32'h100);
        end
        do_req(1'b0, 4'h0, 32'h0, 32'h0, got);
        do_req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, got);
        checks++;
        if (got !== 32'h102) begin
            errors++;
            $display("FAIL timer_count: got %h want %h", got, 32'h102);
        end
        do_req(1'b1, 4'hf, 32'hbfaf_f000, 32'hFFFF_0F0F, got);
        checks++;
        if (led !== 16'h0F0F) begin
            errors++;
            $display("FAIL led_out: got %h want %h", led, 16'h0F0F);
        end
        do_req(1'b1, 4'h0, 32'hbfaf_f000, 32'h0, got);
        checks++;
        if (got !== 32'h0000_0F0F) begin
            errors++;
            $display("FAIL led_read: got %h want %h", got, 32'h0000_0F0F);
        end
        do_req(1'b1, 4'hf, 32'hbfaf_f020, 32'hCAFE_BABE, got);
        do_req(1'b1, 4'b0101, 32'hbfaf_f020, 32'h0011_0022, got);
        do_req(1'b1, 4'h0, 32'hbfaf_f020, 32'h0, got);
        checks++;
        if (got !== 32'hCA11_BA22) begin
            errors++;
            $display("FAIL scratch: got %h want %h", got, 32'hCA11_BA22);
        end
        do_req(1'b1, 4'hf, 32'hbfaf_0040, 32'h7777_7777, got);
        do_req(1'b1, 4'h0, 32'hbfaf_0040, 32'h0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL unmapped: got %h want %h", got, 32'h0);
        end
        model_req(1'b1, 4'h0, 32'h40, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h40, 32'h0, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL window_no_array: got %h want %h", got, exp);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] got;
        logic [31:0] exp;
        model_req(1'b1, 4'hf, 32'h80, 32'h5, exp);
        do_req(1'b1, 4'hf, 32'h80, 32'h5, got);
        model_req(1'b1, 4'h0, 32'h80, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h80, 32'h0, got);
        reset = 1'b1;
        do_req(1'b1, 4'hf, 32'h80, 32'hDEAD, got);
        reset = 1'b0;
        last_rd = 32'h0;
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_rdata: got %h want %h", got, 32'h0);
        end
        checks++;
        if (led !== 16'hffff) begin
            errors++;
            $display("FAIL reset_mid_led: got %h want %h", led, 16'hffff);
        end
`ifdef SRAM_RESP_CONFREG_EN
        do_req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL reset_timer: got %h want %h", got, 32'h0);
        end
        do_req(1'b1, 4'h0, 32'hbfaf_f020, 32'h0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL reset_scratch: got %h want %h", got, 32'h0);
        end
`endif
        model_req(1'b1, 4'h0, 32'h80, 32'h0, exp);
        do_req(1'b1, 4'h0, 32'h80, 32'h0, got);
        checks++;
        if (got !== 32'h5 || got !== exp) begin
            errors++;
            $display("FAIL reset_mid_persist: got %h want %h", got, 32'h5);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_partial;
        test_read_first;
        test_idle_hold;
        test_random;
`ifdef SRAM_RESP_CONFREG_EN
        test_confreg;
`endif
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
